clock_datapath: RTL and testbench
=================================

# clock_datapath

Register/ALU datapath that executes the control strobes issued by the digital-clock PLA controllers (timer set, time update, timer compare). It returns status flags and the one-second update tick to those controllers. It owns the shared 6-bit data bus, registers A, B and R, the ALU, and the seconds prescaler. It sits directly under the top-level board, between the controllers and the time/date storage.

## Interface
Parameters:
- WIDTH, 6, datapath and bus width in bits
- TICK_DIV, 500, clk cycles per update tick (500 × 2 ms = 1 s); must be ≥ 2

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- la  in  1  load A from bus
- lb  in  1  load B from bus
- lr  in  1  load R from ALU result; capture carry into cc
- ea  in  1  drive A onto bus
- er  in  1  drive R onto bus
- ext_en  in  1  drive ext_data onto bus
- ext_data  in  WIDTH  external value (keypad/set path)
- s  in  2  ALU operation select
- cin  in  1  ALU carry-in (add only)
- kc  in  1  clear prescaler
- bus  out  WIDTH  current bus value
- a_q, b_q, r_q  out  WIDTH  register contents
- az  out  1  A == 0
- m  out  1  R == B
- cc  out  1  carry captured by the last lr
- u  out  1  update tick, one cycle wide
- bus_err  out  1  sticky bus-contention flag

## Operation
Bus:
- Combinational priority mux: ea > er > ext_en.
- Bus reads 0 when no driver is enabled.
- More than one driver enabled in a cycle sets bus_err on the next edge. The flag is sticky until reset. The priority winner is still used.

Loads, all on the same edge:
- la: A <= bus
- lb: B <= bus
- lr: R <= alu_y, cc <= alu_co
- The ALU and bus always use pre-edge register values. Simultaneous la and lr is therefore legal: R gets the result computed from the old A.

ALU, combinational, results are mod 2^WIDTH:
- s=00: y = A+B+cin; co = carry out
- s=01: y = A−B (A + ~B + 1); co = 1 when A ≥ B (no borrow)
- s=10: y = A+1; co = 1 when A was all-ones
- s=11: y = B; co = 0

Status:
- az and m are combinational from the registers.
- Both are valid in the cycle after the load edge.

Prescaler:
- cnt runs 0..TICK_DIV−1 and wraps.
- u = (cnt == TICK_DIV−1) && !kc.
- kc forces cnt <= 0 next edge, regardless of its current value.

Reset:
- rst_n low overrides every strobe.
- A, B, R, cc, cnt, bus_err <= 0.
- Resulting outputs: az=1, m=1, u=0, bus=0 when undriven.

## Timing
- Strobes are sampled on the rising edge; register outputs update at that edge.
- Load-to-flag latency: 1 cycle.
- First u occurs TICK_DIV−1 cycles after the first cycle with rst_n high. Period is then TICK_DIV.
- After kc is sampled in cycle k, the next u occurs in cycle k+TICK_DIV.
- Controllers may change strobes every cycle; no handshake or stall exists.

## Configuration
- BUS_CHECK_EN defined: contention detector is present and bus_err behaves as above.
- BUS_CHECK_EN undefined: detector is removed and bus_err is tied to 0. Bus priority behaviour is identical in both builds.

## Structure
- Package clock_dp_pkg holds:
  - WIDTH default
  - ALU op constants OP_ADD=2'b00, OP_SUB=2'b01, OP_INC=2'b10, OP_PASSB=2'b11
- One sub-module, dp_alu: combinational, parameterised by WIDTH, ports a, b, s, cin, y, co.
- Registers, bus mux and prescaler stay in clock_datapath.

## Test plan
- Reset: hold rst_n low 2 cycles with all strobes high → a_q=b_q=r_q=0, az=1, m=1, cc=0, u=0, bus_err=0.
- Add and increment:
  - ext 23 with la → a_q=23, az=0.
  - ext 40 with lb → b_q=40.
  - s=00, cin=0, lr → r_q=63, cc=0.
  - A=63, s=10, lr → r_q=0, cc=1.
- Subtract:
  - A=5, B=7, s=01, lr → r_q=62, cc=0.
  - A=7, B=5 → r_q=2, cc=1.
  - Then B=2, lb → m=1.
- Contention (BUS_CHECK_EN defined): A=3, R=9, ea=er=1 with lb → b_q=3, bus_err=1, which stays 1 for 10 idle cycles and clears only on reset.
- Simultaneous load: A=10, B=1, s=00, ext 20 with la and lr in the same cycle → r_q=11, a_q=20.
- Tick (TICK_DIV=4): u high in post-reset cycles 3, 7, 11. With kc in cycle 5, u is high in cycle 9 and absent in cycle 7.

Source files
------------

// File: rtl/clock_datapath_pkg.sv
// clock_dp_pkg: shared constants for the digital-clock register/ALU datapath.
//   WIDTH_DEF - default datapath and bus width
//   alu_op_e  - ALU operation select codes (OP_ADD, OP_SUB, OP_INC, OP_PASSB)
package clock_dp_pkg;

    localparam int WIDTH_DEF = 6;

    typedef enum logic [1:0] {
        OP_ADD   = 2'b00,
        OP_SUB   = 2'b01,
        OP_INC   = 2'b10,
        OP_PASSB = 2'b11
    } alu_op_e;

endpackage

// File: rtl/clock_datapath_if.sv
// clock_datapath_if: strobes from the PLA controllers and status returned to them.
//   master - controller side: drives la/lb/lr/ea/er/ext_en/ext_data/s/cin/kc,
//            observes bus, a_q/b_q/r_q, az, m, cc, u, bus_err
//   slave  - datapath side: the mirror image
interface clock_datapath_if import clock_dp_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
);
    logic             la;
    logic             lb;
    logic             lr;
    logic             ea;
    logic             er;
    logic             ext_en;
    logic [WIDTH-1:0] ext_data;
    logic [1:0]       s;
    logic             cin;
    logic             kc;

    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] r_q;
    logic             az;
    logic             m;
    logic             cc;
    logic             u;
    logic             bus_err;

    modport master (
        output la, lb, lr, ea, er, ext_en, ext_data, s, cin, kc,
        input  bus, a_q, b_q, r_q, az, m, cc, u, bus_err
    );

    modport slave (
        input  la, lb, lr, ea, er, ext_en, ext_data, s, cin, kc,
        output bus, a_q, b_q, r_q, az, m, cc, u, bus_err
    );
endinterface

// File: rtl/clock_datapath_alu.sv
// dp_alu: combinational ALU for the clock datapath. Results are mod 2^WIDTH.
//   a, b - operands          s  - operation (alu_op_e)
//   cin  - carry-in (add)    y  - result      co - carry / no-borrow flag
module dp_alu import clock_dp_pkg::*; #(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       s,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             co
);
    logic [WIDTH:0] sum;

    // One WIDTH+1 adder view per op; the top bit is the carry in every case,
    // which gives "A >= B" for subtract and "A was all-ones" for increment.
    always_comb begin
        sum = '0;
        case (alu_op_e'(s))
            OP_ADD:   sum = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            OP_SUB:   sum = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
            OP_INC:   sum = {1'b0, a} + (WIDTH+1)'(1);
            OP_PASSB: sum = {1'b0, b};
            default:  sum = '0;
        endcase
        y  = sum[WIDTH-1:0];
        co = sum[WIDTH];
    end
endmodule

// File: rtl/clock_datapath.sv
// clock_datapath: registers A/B/R, shared bus, ALU and seconds prescaler for the
// digital-clock controllers.
//   clk   - system clock        rst_n - synchronous active-low reset
//   dp    - clock_datapath_if.slave (strobes in, bus/registers/flags out)
// Build option: define BUS_CHECK_EN to include the sticky bus-contention
// detector; otherwise bus_err is tied low. Bus priority is the same either way.
module clock_datapath import clock_dp_pkg::*; #(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int TICK_DIV = 500
) (
    input  logic            clk,
    input  logic            rst_n,
    clock_datapath_if.slave dp
);
    localparam int             CW       = $clog2(TICK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TICK_DIV - 1);

    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d;
    logic             cc_q, cc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bus_err_q, bus_err_d;
    logic [WIDTH-1:0] bus;
    logic [WIDTH-1:0] alu_y;
    logic             alu_co;

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_q),
        .b   (b_q),
        .s   (dp.s),
        .cin (dp.cin),
        .y   (alu_y),
        .co  (alu_co)
    );

    always_comb begin
        if (dp.ea)          bus = a_q;
        else if (dp.er)     bus = r_q;
        else if (dp.ext_en) bus = dp.ext_data;
        else                bus = '0;
    end

    always_comb begin
        a_d  = a_q;
        b_d  = b_q;
        r_d  = r_q;
        cc_d = cc_q;
        if (dp.la) a_d = bus;
        if (dp.lb) b_d = bus;
        if (dp.lr) begin
            r_d  = alu_y;
            cc_d = alu_co;
        end
        if (dp.kc || cnt_q == CNT_LAST) cnt_d = '0;
        else                            cnt_d = cnt_q + CW'(1);
    end

`ifdef BUS_CHECK_EN
    logic [1:0] n_drv;
    always_comb begin
        n_drv     = 2'(dp.ea) + 2'(dp.er) + 2'(dp.ext_en);
        bus_err_d = bus_err_q | (n_drv > 2'd1);
    end
`else
    always_comb bus_err_d = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            r_q       <= '0;
            cc_q      <= 1'b0;
            cnt_q     <= '0;
            bus_err_q <= 1'b0;
        end else begin
            a_q       <= a_d;
            b_q       <= b_d;
            r_q       <= r_d;
            cc_q      <= cc_d;
            cnt_q     <= cnt_d;
            bus_err_q <= bus_err_d;
        end
    end

    assign dp.bus     = bus;
    assign dp.a_q     = a_q;
    assign dp.b_q     = b_q;
    assign dp.r_q     = r_q;
    assign dp.az      = (a_q == '0);
    assign dp.m       = (r_q == b_q);
    assign dp.cc      = cc_q;
    // A clear request masks the tick in the very cycle it is asserted.
    assign dp.u       = (cnt_q == CNT_LAST) && !dp.kc;
    assign dp.bus_err = bus_err_q;
endmodule

// File: tb/tb_clock_datapath.sv
module tb_clock_datapath;
    import clock_dp_pkg::*;

    localparam int W  = 6;
    localparam int TD = 4;
`ifdef BUS_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    clock_datapath_if #(.WIDTH(W)) dp_if ();

    clock_datapath #(.WIDTH(W), .TICK_DIV(TD)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .dp    (dp_if)
    );

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic       la, lb, lr, ea, er, ext_en;
        logic [5:0] ext;
        logic [1:0] s;
        logic       cin;
        logic [5:0] e_bus, e_a, e_b, e_r;
        logic       e_cc, e_az, e_m;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic la, logic lb, logic lr, logic ea, logic er, logic ext_en,
                                logic [5:0] ext, logic [1:0] s, logic cin,
                                logic [5:0] e_bus, logic [5:0] e_a, logic [5:0] e_b,
                                logic [5:0] e_r, logic e_cc, logic e_az, logic e_m);
        vec_t v;
        v.la = la; v.lb = lb; v.lr = lr; v.ea = ea; v.er = er; v.ext_en = ext_en;
        v.ext = ext; v.s = s; v.cin = cin;
        v.e_bus = e_bus; v.e_a = e_a; v.e_b = e_b; v.e_r = e_r;
        v.e_cc = e_cc; v.e_az = e_az; v.e_m = e_m;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic la, input logic lb, input logic lr, input logic ea,
                         input logic er, input logic ext_en, input logic [5:0] ext,
                         input logic [1:0] s, input logic cin, input logic kc);
        dp_if.la = la; dp_if.lb = lb; dp_if.lr = lr;
        dp_if.ea = ea; dp_if.er = er; dp_if.ext_en = ext_en;
        dp_if.ext_data = ext; dp_if.s = s; dp_if.cin = cin; dp_if.kc = kc;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 6'd0, 2'b00, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    // behavioural reference state
    int ma, mb, mr, mcc, mk_cyc, merr;

    initial begin
        int sel, kc_i, ea_i, er_i, ex_i, la_i, lb_i, lr_i, cin_i, s_i, ext_i;
        int e_bus, y, co, ndrv;

        // ---------------- reset with every strobe high ----------------
        drive(1, 1, 1, 1, 1, 1, 6'd63, 2'b10, 1, 1);
        rst_n = 1'b0;
        step();
        step();
        chk("rst_a", 32'(dp_if.a_q), 0);
        chk("rst_b", 32'(dp_if.b_q), 0);
        chk("rst_r", 32'(dp_if.r_q), 0);
        chk("rst_az", 32'(dp_if.az), 1);
        chk("rst_m", 32'(dp_if.m), 1);
        chk("rst_cc", 32'(dp_if.cc), 0);
        chk("rst_u", 32'(dp_if.u), 0);
        chk("rst_bus_err", 32'(dp_if.bus_err), 0);
        idle();
        #1;
        chk("rst_bus_undriven", 32'(dp_if.bus), 0);

        // ---------------- tick timing ----------------
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("tick_c%0d", c), 32'(dp_if.u), ((c % TD) == TD - 1) ? 1 : 0);
            step();
        end
        do_reset();
        for (int c = 0; c < 11; c++) begin
            dp_if.kc = (c == 5);
            #1;
            chk($sformatf("kc_tick_c%0d", c), 32'(dp_if.u), (c == 3 || c == 9) ? 1 : 0);
            step();
        end
        idle();

        // ---------------- table-driven loads / ALU ----------------
        do_reset();
        //             la lb lr ea er ex ext s     cin  bus a   b   r   cc az m
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 23, 2'b00, 0, 23, 23,  0,  0, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 40, 2'b00, 0, 40, 23, 40,  0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b00, 0,  0, 23, 40, 63, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 63, 2'b00, 0, 63, 63, 40, 63, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b10, 0,  0, 63, 40,  0, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,  5, 2'b00, 0,  5,  5, 40,  0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  7, 2'b00, 0,  7,  5,  7,  0, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b01, 0,  0,  5,  7, 62, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,  7, 2'b00, 0,  7,  7,  7, 62, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  5, 2'b00, 0,  5,  7,  5, 62, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b01, 0,  0,  7,  5,  2, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  2, 2'b00, 0,  2,  7,  2,  2, 1, 0, 1));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 10, 2'b00, 0, 10, 10,  2,  2, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  1, 2'b00, 0,  1, 10,  1,  2, 1, 0, 0));
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 20, 2'b00, 0, 20, 20,  1, 11, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b00, 1,  0, 20,  1, 22, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b11, 0,  0, 20,  1,  1, 0, 0, 1));
        vecs.push_back(mk(0, 1, 0, 1, 0, 0,  0, 2'b00, 0, 20, 20, 20,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 1, 0,  0, 2'b00, 0,  1,  1, 20,  1, 0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1, 50, 2'b00, 0, 50,  1, 50,  1, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 40, 2'b00, 0, 40, 40, 50,  1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b00, 1,  0, 40, 50, 27, 1, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1,  0, 2'b00, 0,  0,  0, 50, 27, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b01, 0,  0,  0, 50, 14, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 0,  0, 2'b10, 0,  0,  0, 50,  1, 0, 1, 0));
        vecs.push_back(mk(0, 1, 0, 0, 0, 1,  1, 2'b00, 0,  1,  0,  1,  1, 0, 1, 1));
        foreach (vecs[i]) begin
            drive(vecs[i].la, vecs[i].lb, vecs[i].lr, vecs[i].ea, vecs[i].er, vecs[i].ext_en,
                  vecs[i].ext, vecs[i].s, vecs[i].cin, 0);
            #1;
            chk($sformatf("v%0d_bus", i), 32'(dp_if.bus), 32'(vecs[i].e_bus));
            step();
            chk($sformatf("v%0d_a", i), 32'(dp_if.a_q), 32'(vecs[i].e_a));
            chk($sformatf("v%0d_b", i), 32'(dp_if.b_q), 32'(vecs[i].e_b));
            chk($sformatf("v%0d_r", i), 32'(dp_if.r_q), 32'(vecs[i].e_r));
            chk($sformatf("v%0d_cc", i), 32'(dp_if.cc), 32'(vecs[i].e_cc));
            chk($sformatf("v%0d_az", i), 32'(dp_if.az), 32'(vecs[i].e_az));
            chk($sformatf("v%0d_m", i), 32'(dp_if.m), 32'(vecs[i].e_m));
            chk($sformatf("v%0d_bus_err", i), 32'(dp_if.bus_err), 0);
        end

        // ---------------- contention / priority ----------------
        drive(1, 0, 0, 0, 0, 1, 6'd3, 2'b00, 0, 0); step();
        drive(0, 1, 0, 0, 0, 1, 6'd9, 2'b00, 0, 0); step();
        drive(0, 0, 1, 0, 0, 0, 6'd0, 2'b11, 0, 0); step();
        chk("cont_pre_r", 32'(dp_if.r_q), 9);
        drive(0, 1, 0, 1, 1, 0, 6'd0, 2'b00, 0, 0);
        #1;
        chk("cont_bus_prio", 32'(dp_if.bus), 3);
        step();
        chk("cont_b", 32'(dp_if.b_q), 3);
        chk("cont_bus_err", 32'(dp_if.bus_err), CHK);
        idle();
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("cont_sticky_%0d", c), 32'(dp_if.bus_err), CHK);
        end
        drive(0, 0, 0, 0, 1, 1, 6'd40, 2'b00, 0, 0);
        #1;
        chk("prio_er_over_ext", 32'(dp_if.bus), 9);
        idle();
        do_reset();
        chk("cont_cleared", 32'(dp_if.bus_err), 0);

        // ---------------- randomized vs reference model ----------------
        do_reset();
        ma = 0; mb = 0; mr = 0; mcc = 0; mk_cyc = 0; merr = 0;
        for (int i = 0; i < 400; i++) begin
            sel   = $urandom_range(0, 11);
            ea_i  = (sel == 1 || sel == 9) ? 1 : 0;
            er_i  = (sel == 2 || sel == 3 || sel == 9 || sel == 10) ? 1 : 0;
            ex_i  = (sel == 4 || sel == 5 || sel == 6 || sel == 10) ? 1 : 0;
            la_i  = $urandom_range(0, 2) == 0 ? 1 : 0;
            lb_i  = $urandom_range(0, 2) == 0 ? 1 : 0;
            lr_i  = $urandom_range(0, 1);
            cin_i = $urandom_range(0, 1);
            s_i   = $urandom_range(0, 3);
            ext_i = $urandom_range(0, 63);
            kc_i  = $urandom_range(0, 15) == 0 ? 1 : 0;
            drive(la_i[0], lb_i[0], lr_i[0], ea_i[0], er_i[0], ex_i[0], 6'(ext_i), 2'(s_i),
                  cin_i[0], kc_i[0]);
            #1;
            e_bus = ea_i ? ma : er_i ? mr : ex_i ? ext_i : 0;
            chk("rnd_bus", 32'(dp_if.bus), e_bus);
            chk("rnd_u", 32'(dp_if.u), ((mk_cyc % TD) == TD - 1 && kc_i == 0) ? 1 : 0);
            case (s_i)
                0: begin y = (ma + mb + cin_i) % 64; co = (ma + mb + cin_i) >= 64 ? 1 : 0; end
                1: begin y = (ma - mb + 64) % 64;    co = (ma >= mb) ? 1 : 0; end
                2: begin y = (ma + 1) % 64;          co = (ma == 63) ? 1 : 0; end
                default: begin y = mb; co = 0; end
            endcase
            ndrv = ea_i + er_i + ex_i;
            if (lr_i != 0) begin mr = y; mcc = co; end
            if (la_i != 0) ma = e_bus;
            if (lb_i != 0) mb = e_bus;
            if (CHK != 0 && ndrv > 1) merr = 1;
            mk_cyc = (kc_i != 0) ? 0 : mk_cyc + 1;
            step();
            chk("rnd_a", 32'(dp_if.a_q), ma);
            chk("rnd_b", 32'(dp_if.b_q), mb);
            chk("rnd_r", 32'(dp_if.r_q), mr);
            chk("rnd_cc", 32'(dp_if.cc), mcc);
            chk("rnd_az", 32'(dp_if.az), (ma == 0) ? 1 : 0);
            chk("rnd_m", 32'(dp_if.m), (mr == mb) ? 1 : 0);
            chk("rnd_bus_err", 32'(dp_if.bus_err), merr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
